// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants and the pixel/control types shared by the VGA scan-out.
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FB_DEPTH = 307200;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic first;
  } ctl_t;
  localparam ctl_t CTL_IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1, first: 1'b0};
endpackage

// File: rtl/vga_timing.sv
// vga_timing: h/v raster counters, active/sync decode and the incremental frame-buffer address.
module vga_timing
  import vga_pkg::*;
#(
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  output logic              active,
  output logic              hs,
  output logic              vs,
  output logic              first,
  output logic [ADDR_W-1:0] addr
);
  logic [9:0] h, v;
  logic h_end, v_end;
  assign h_end = h == 10'(H_TOTAL - 1);
  assign v_end = v == 10'(V_TOTAL - 1);
  assign active = h < 10'(H_ACTIVE) && v < 10'(V_ACTIVE);
  assign hs = !(h >= 10'(H_ACTIVE + H_FP) && h < 10'(H_ACTIVE + H_FP + H_SYNC));
  assign vs = !(v >= 10'(V_ACTIVE + V_FP) && v < 10'(V_ACTIVE + V_FP + V_SYNC));
  assign first = h == '0 && v == '0;
  // the address only counts displayed pixels, so it always equals y*640+x without a multiplier
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      h <= '0;
      v <= '0;
      addr <= '0;
    end else begin
      h <= h_end ? '0 : h + 10'd1;
      if (h_end) v <= v_end ? '0 : v + 10'd1;
      addr <= (h_end && v_end) ? '0 : active ? addr + ADDR_W'(1) : addr;
    end
endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480@60 VGA scan-out from the frame-buffer BRAM, with read-latency
// compensation so colour, sync and frame_start stay aligned.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int ADDR_W = 19
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cam_done,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_en,
  input  logic [11:0]       i_rd_data,
  output logic [3:0]        o_vga_r,
  output logic [3:0]        o_vga_g,
  output logic [3:0]        o_vga_b,
  output logic              o_hsync,
  output logic              o_vsync,
  output logic              o_frame_start
);
  ctl_t cur, dly [RD_LATENCY];
  logic active, hs, vs, first;
  logic [1:0] cam_sync;
  logic cam_frame, show;
  rgb444_t pix;
  vga_timing #(.ADDR_W(ADDR_W)) u_tim (
    .clk(i_clk),
    .rst(i_rst),
    .active(active),
    .hs(hs),
    .vs(vs),
    .first(first),
    .addr(o_rd_addr)
  );
  assign cur = {active, hs, vs, first};
  assign o_rd_en = active & ~i_rst;
  // camera readiness is latched only as pixel (0,0) leaves the delay line, so frames are never partial
  assign show = dly[RD_LATENCY-1].first ? cam_sync[1] : cam_frame;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      cam_sync <= '0;
      cam_frame <= 1'b0;
      for (int i = 0; i < RD_LATENCY; i++) dly[i] <= CTL_IDLE;
      pix <= '0;
      o_hsync <= 1'b1;
      o_vsync <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      cam_sync <= {cam_sync[0], i_cam_done};
      cam_frame <= show;
      dly[0] <= cur;
      for (int i = 1; i < RD_LATENCY; i++) dly[i] <= dly[i-1];
      pix <= (dly[RD_LATENCY-1].act && show) ? rgb444_t'(i_rd_data) : '0;
      o_hsync <= dly[RD_LATENCY-1].hs;
      o_vsync <= dly[RD_LATENCY-1].vs;
      o_frame_start <= dly[RD_LATENCY-1].first;
    end
  assign o_vga_r = pix.r;
  assign o_vga_g = pix.g;
  assign o_vga_b = pix.b;
endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: two readers (latency 1 and 3) checked cycle by cycle against a raster model.
module tb_vga_frame_reader;
  localparam int NL = 2;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam logic [34:0] RST_O = {1'b0, 19'd0, 12'd0, 3'b110};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cam = 1'b0;
  logic [18:0] rd_addr [NL];
  logic rd_en [NL];
  logic [11:0] rd_data [NL];
  logic [3:0] r [NL], g [NL], b [NL];
  logic hs [NL], vs [NL], fs [NL];
  logic [11:0] bq [NL][4];

  int checks = 0, failures = 0;
  int k, mh, mv;
  bit fresh;
  int hh [8], hv [8];
  bit hc [8];
  bit gate [NL];
  logic [34:0] exp_o [NL], obs [NL];
  logic [9:0] jv_f;
  logic [18:0] ja_f;

  always #20 clk = ~clk;

  vga_frame_reader #(.RD_LATENCY(LAT0), .ADDR_W(19)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_cam_done(cam), .o_rd_addr(rd_addr[0]), .o_rd_en(rd_en[0]),
    .i_rd_data(rd_data[0]), .o_vga_r(r[0]), .o_vga_g(g[0]), .o_vga_b(b[0]),
    .o_hsync(hs[0]), .o_vsync(vs[0]), .o_frame_start(fs[0]));
  vga_frame_reader #(.RD_LATENCY(LAT1), .ADDR_W(19)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_cam_done(cam), .o_rd_addr(rd_addr[1]), .o_rd_en(rd_en[1]),
    .i_rd_data(rd_data[1]), .o_vga_r(r[1]), .o_vga_g(g[1]), .o_vga_b(b[1]),
    .o_hsync(hs[1]), .o_vsync(vs[1]), .o_frame_start(fs[1]));

  // BRAM model: returns addr[11:0] RD_LATENCY clocks after the address, junk when not reading
  always @(posedge clk)
    for (int i = 0; i < NL; i++) begin
      bq[i][0] <= rd_en[i] ? rd_addr[i][11:0] : 12'($urandom);
      for (int s = 1; s < 4; s++) bq[i][s] <= bq[i][s-1];
    end
  assign rd_data[0] = bq[0][LAT0-1];
  assign rd_data[1] = bq[1][LAT1-1];

  function automatic int lat(input int i);
    return i == 0 ? LAT0 : LAT1;
  endfunction

  function automatic logic [34:0] sample(input int i);
    return {rd_en[i], rd_addr[i], r[i], g[i], b[i], hs[i], vs[i], fs[i]};
  endfunction

  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
    k = -1;
    fresh = 1'b1;
    mh = 0;
    mv = 0;
    gate[0] = 1'b0;
    gate[1] = 1'b0;
  endtask

  // advance one pixel clock; optional jump to the start of line jv; fills exp_o/obs
  task automatic tick(input bit cv, input int jv);
    int j, ph, pv, ea;
    bit first, act;
    logic [11:0] px;
    @(negedge clk);
    cam = cv;
    k++;
    if (!fresh) begin
      mh++;
      if (mh == 800) begin
        mh = 0;
        mv = (mv == 524) ? 0 : mv + 1;
      end
    end
    fresh = 1'b0;
    if (jv >= 0) begin
      mv = jv;
      jv_f = 10'(jv);
      ja_f = 19'((jv < 480 ? jv : 480) * 640);
      force dut0.u_tim.v = jv_f;
      force dut0.u_tim.addr = ja_f;
      force dut1.u_tim.v = jv_f;
      force dut1.u_tim.addr = ja_f;
      #1;
      release dut0.u_tim.v;
      release dut0.u_tim.addr;
      release dut1.u_tim.v;
      release dut1.u_tim.addr;
    end
    hh[k%8] = mh;
    hv[k%8] = mv;
    hc[k%8] = cv;
    #1;
    ea = mv < 480 ? mv * 640 + (mh < 640 ? mh : 640) : 307200;
    for (int i = 0; i < NL; i++) begin
      j = k - lat(i) - 1;
      if (j < 0) exp_o[i] = {mh < 640 && mv < 480, 19'(ea), 12'd0, 3'b110};
      else begin
        ph = hh[j%8];
        pv = hv[j%8];
        first = ph == 0 && pv == 0;
        if (first) gate[i] = (k >= 3) ? hc[(k-3)%8] : 1'b0;
        act = ph < 640 && pv < 480;
        px = (act && gate[i]) ? 12'(pv * 640 + ph) : 12'd0;
        exp_o[i] = {mh < 640 && mv < 480, 19'(ea), px, !(ph >= 656 && ph < 752),
                    !(pv >= 490 && pv < 492), first};
      end
      obs[i] = sample(i);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cam = 1'b0;
    repeat (5) begin
      @(negedge clk);
      for (int i = 0; i < NL; i++) begin
        checks++;
        if (sample(i) !== RST_O) begin
          failures++;
          $display("FAIL reset dut%0d got=%h exp=%h", i, sample(i), RST_O);
        end
      end
    end
    release_rst();
  endtask

  task automatic test_line_timing();
    int first_low [NL];
    int low_cnt [NL];
    for (int i = 0; i < NL; i++) begin
      first_low[i] = -1;
      low_cnt[i] = 0;
    end
    repeat (1600) begin
      tick(1'b0, -1);
      for (int i = 0; i < NL; i++) begin
        checks++;
        if (obs[i] !== exp_o[i]) begin
          failures++;
          if (failures < 30) $display("FAIL line_timing dut%0d k=%0d h=%0d v=%0d got=%h exp=%h", i, k, mh, mv, obs[i], exp_o[i]);
        end
        if (!hs[i]) begin
          low_cnt[i]++;
          if (first_low[i] < 0) first_low[i] = k;
        end
      end
    end
    for (int i = 0; i < NL; i++) begin
      checks++;
      if (first_low[i] != 656 + lat(i) + 1) begin
        failures++;
        $display("FAIL hsync_first dut%0d got=%0d exp=%0d", i, first_low[i], 656 + lat(i) + 1);
      end
      checks++;
      if (low_cnt[i] != 192) begin
        failures++;
        $display("FAIL hsync_low dut%0d got=%0d exp=192", i, low_cnt[i]);
      end
    end
  endtask

  task automatic test_cam_gating();
    int rise = $urandom_range(0, 799);
    int nz [NL];
    bit c = 1'b0;
    nz[0] = 0;
    nz[1] = 0;
    for (int n = 0; n < 2400; n++) begin
      tick(c, n == 0 ? 199 : -1);
      for (int i = 0; i < NL; i++) begin
        checks++;
        if (obs[i] !== exp_o[i]) begin
          failures++;
          if (failures < 30) $display("FAIL cam_gating dut%0d k=%0d h=%0d v=%0d got=%h exp=%h", i, k, mh, mv, obs[i], exp_o[i]);
        end
        if ({r[i], g[i], b[i]} != 12'd0) nz[i]++;
      end
      if (mv == 200 && mh == rise) c = 1'b1;
    end
    for (int i = 0; i < NL; i++) begin
      checks++;
      if (nz[i] != 0) begin
        failures++;
        $display("FAIL cam_black dut%0d got=%0d exp=0", i, nz[i]);
      end
    end
  endtask

  task automatic test_frame_wrap();
    int vlow [NL], fcnt [NL], nz [NL];
    logic [18:0] last [NL];
    for (int i = 0; i < NL; i++) begin
      vlow[i] = 0;
      fcnt[i] = 0;
      nz[i] = 0;
      last[i] = '0;
    end
    for (int n = 0; n < 34400; n++) begin
      tick(1'b1, n == 0 ? 478 : n == 2400 ? 487 : -1);
      for (int i = 0; i < NL; i++) begin
        checks++;
        if (obs[i] !== exp_o[i]) begin
          failures++;
          if (failures < 30) $display("FAIL frame_wrap dut%0d k=%0d h=%0d v=%0d got=%h exp=%h", i, k, mh, mv, obs[i], exp_o[i]);
        end
        if (mv == 0 && mh == 0) begin
          checks++;
          if (last[i] !== 19'd307199 || rd_addr[i] !== 19'd0 || rd_en[i] !== 1'b1) begin
            failures++;
            $display("FAIL addr_wrap dut%0d last=%0d first=%0d en=%b exp=307199/0/1", i, last[i], rd_addr[i], rd_en[i]);
          end
        end
        if (rd_en[i]) last[i] = rd_addr[i];
        if (!vs[i]) vlow[i]++;
        if (fs[i]) fcnt[i]++;
        if (mv < 10 && {r[i], g[i], b[i]} != 12'd0) nz[i]++;
      end
    end
    for (int i = 0; i < NL; i++) begin
      checks++;
      if (vlow[i] != 1600) begin
        failures++;
        $display("FAIL vsync_low dut%0d got=%0d exp=1600", i, vlow[i]);
      end
      checks++;
      if (fcnt[i] != 1) begin
        failures++;
        $display("FAIL frame_start_count dut%0d got=%0d exp=1", i, fcnt[i]);
      end
      checks++;
      if (nz[i] == 0) begin
        failures++;
        $display("FAIL frame1_shown dut%0d got=0 exp=nonzero", i);
      end
    end
  endtask

  task automatic test_random_lines();
    repeat (3) begin
      int jv = $urandom_range(2, 470);
      for (int n = 0; n < 1600; n++) begin
        tick(1'($urandom_range(0, 1)), n == 0 ? jv : -1);
        for (int i = 0; i < NL; i++) begin
          checks++;
          if (obs[i] !== exp_o[i]) begin
            failures++;
            if (failures < 30) $display("FAIL random_lines dut%0d k=%0d h=%0d v=%0d got=%h exp=%h", i, k, mh, mv, obs[i], exp_o[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_line();
    for (int n = 0; n <= 300; n++) begin
      tick(1'b1, n == 0 ? 100 : -1);
      for (int i = 0; i < NL; i++) begin
        checks++;
        if (obs[i] !== exp_o[i]) begin
          failures++;
          if (failures < 30) $display("FAIL pre_reset dut%0d k=%0d h=%0d v=%0d got=%h exp=%h", i, k, mh, mv, obs[i], exp_o[i]);
        end
      end
    end
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NL; i++) begin
      checks++;
      if (sample(i) !== RST_O) begin
        failures++;
        $display("FAIL reset_async dut%0d got=%h exp=%h", i, sample(i), RST_O);
      end
    end
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < NL; i++) begin
        checks++;
        if (sample(i) !== RST_O) begin
          failures++;
          $display("FAIL reset_hold dut%0d got=%h exp=%h", i, sample(i), RST_O);
        end
      end
    end
    release_rst();
    repeat (1600) begin
      tick(1'b1, -1);
      for (int i = 0; i < NL; i++) begin
        checks++;
        if (obs[i] !== exp_o[i]) begin
          failures++;
          if (failures < 30) $display("FAIL post_reset dut%0d k=%0d h=%0d v=%0d got=%h exp=%h", i, k, mh, mv, obs[i], exp_o[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_cam_gating();
    test_frame_wrap();
    test_random_lines();
    test_reset_mid_line();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Display-side consumer of the camera frame buffer. It generates 640x480@60 VGA timing and reads RGB444 pixels from the read port of the dual-port BRAM that the capture path fills through `o_pix_wr`/`o_pix_addr`/`o_pix_data`. It drives the VGA connector and compensates for BRAM read latency so that colour, sync and blanking stay aligned. Until the camera reports that initialisation is done, it outputs black with valid sync.

## Interface
- `RD_LATENCY`, default 2: BRAM read latency in clocks, from address to data; legal range 1..4.
- `ADDR_W`, default 19: frame-buffer address width; must match the capture-side address.
- `i_clk`, in, 1: 25 MHz pixel clock; this is the only clock.
- `i_rst`, in, 1: reset, asynchronous and active-high.
- `i_cam_done`, in, 1: camera initialisation complete; synchronised inside the block with 2 flops.
- `o_rd_addr`, out, ADDR_W: BRAM read address.
- `o_rd_en`, out, 1: BRAM read enable.
- `i_rd_data`, in, 12: BRAM read data, {R[3:0],G[3:0],B[3:0]}.
- `o_vga_r`, `o_vga_g`, `o_vga_b`, out, 4 each: colour outputs.
- `o_hsync`, `o_vsync`, out, 1 each: sync outputs, active-low.
- `o_frame_start`, out, 1: single-cycle pulse when the first active pixel of a frame appears on the colour outputs.

## Operation
- Horizontal counter `h` runs 0..799: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical counter `v` runs 0..524 and advances when `h` wraps: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Active region: `h`<640 and `v`<480.
- `o_rd_en` is high exactly in the active region.
- Address generation is incremental; the block contains no multiplier.
  - Address counter resets to 0 when `h`=799 and `v`=524.
  - It increments by 1 on each active cycle.
  - `o_rd_addr` equals the counter, so the address for pixel (x,y) is y*640+x. The range 0..307199 fits in 19 bits.
- Active flag, hsync and vsync pass through a delay line of length RD_LATENCY so they line up with `i_rd_data`.
- Colour output, registered one cycle after the delay line:
  - data if the delayed active flag is set and the synchronised cam_done is 1;
  - otherwise 0.
- Sync outputs are registered in the same stage as colour, so all VGA outputs share one alignment.
- `o_frame_start` is asserted in the output stage for the delayed pixel (0,0).
- cam_done is sampled only at frame start. If it rises mid-frame, the current frame stays black and the next frame shows pixels, so no partial frame is displayed.
- Reset mid-operation: all state clears asynchronously. After reset releases, the counters restart at `h`=0, `v`=0.

## Timing
- Reset values: `h`=0, `v`=0, address 0, `o_rd_en`=0, `o_rd_addr`=0, RGB=0, `o_hsync`=1, `o_vsync`=1, `o_frame_start`=0. The delay line clears to inactive/high.
- Pipeline latency from counter position to VGA pins is RD_LATENCY+1 clocks. It is identical for colour, sync and frame_start.
- `o_rd_en`/`o_rd_addr` are driven directly from counter state, in the same cycle as `h`/`v`.
- Line period is 800 clocks and frame period is 420000 clocks. Both are exact, with no dropped or extra cycles at wrap.
- The vsync edge coincides with the `h`=0 cycle of the line where `v` becomes 490, after the pipeline delay.

## Structure
- The shared package `vga_pkg` holds:
  - localparams `H_ACTIVE`=640, `H_FP`=16, `H_SYNC`=96, `H_BP`=48, `V_ACTIVE`=480, `V_FP`=10, `V_SYNC`=2, `V_BP`=33;
  - derived totals `H_TOTAL` and `V_TOTAL`;
  - `FB_DEPTH`=307200;
  - typedef `rgb444_t`, a packed struct {r,g,b}.
- Sub-module `vga_timing` contains the h/v counters, the active/sync decode and the address counter.
- The top level contains the cam_done synchroniser, the latency delay line and the output register.

## Test plan
- Reset behaviour: hold `i_rst`=1 for 5 cycles, then release. All outputs hold their reset values during reset. The first `o_hsync` low occurs at cycle 656+RD_LATENCY+1 after release.
- Line and frame timing: run 2 frames. Measure exactly 96 low clocks of hsync per line, 800 clocks per line, 1600 clocks of vsync low, and frame_start pulses exactly 420000 cycles apart.
- Address sequence: log `o_rd_addr` while `o_rd_en` is high. It must be 0,1,…,639 on line 0, 640 on the first active cycle of line 1, 307199 last, then 0 on the next frame.
- Latency alignment: use a BRAM model that returns `i_rd_data`=addr[11:0] after RD_LATENCY clocks, with RD_LATENCY set to 1 and then 3. RGB at displayed pixel (x,y) must equal (y*640+x)[11:0], and RGB must be 0 during blanking.
- cam_done gating: keep `i_cam_done`=0 for frame 0 and raise it at `v`=200. RGB stays 0 for the rest of frame 0, and frame 1 shows data from pixel (0,0).
- Reset mid-line: assert `i_rst` at `h`=300, `v`=100 for 3 cycles. The outputs go to reset values immediately, without waiting for a clock edge, and the counters resume at (0,0) after release.
